// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus carrying the in-order port A and the buffered long-latency port B.
interface rf_wb_arbiter_if;
    logic        a_valid;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        stall_a;

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  b_ready, stall_a
    );

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output b_ready, stall_a
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between pipeline writeback (A) and a FIFO of long-latency results (B).
// Define RF_ARB_STATS_EN to add the conflict_cnt / kill_cnt statistics outputs.
module rf_wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic           clk,
    input  logic           reset,
    rf_wb_arbiter_if.slave wb,
    input  logic [4:0]     rs1_addr,
    input  logic [4:0]     rs2_addr,
    output logic           rs1_pending,
    output logic           rs2_pending,
    output logic           RegWrite,
    output logic [4:0]     w_reg_addr,
    output logic [31:0]    w_data
`ifdef RF_ARB_STATS_EN
    ,
    output logic [31:0]    conflict_cnt,
    output logic [31:0]    kill_cnt
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = $clog2(STARVE_LIMIT) + 1;

    typedef enum logic {NORMAL, STARVE} state_t;

    state_t           state, next_state;
    logic [WW-1:0]    wait_cnt, wait_next;

    logic [4:0]       fifo_addr [DEPTH];
    logic [31:0]      fifo_data [DEPTH];
    logic [DEPTH-1:0] fifo_live;
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count;
    logic             w_from_b;

    logic             a_elig, a_win, head_valid, head_live, head_win, head_lose;
    logic             pop, push, push_live;
    logic [4:0]       head_addr;
    logic [31:0]      head_data;
    logic             rs1_hit, rs2_hit;

    assign wb.b_ready = (count != CW'(DEPTH));
    assign wb.stall_a = (state == STARVE);
    assign head_addr  = fifo_addr[rd_ptr];
    assign head_data  = fifo_data[rd_ptr];

    // A head killed by this same A write is about to pop dead, so it is not a starvation loss.
    always_comb begin
        a_elig     = wb.a_valid && (wb.a_addr != 5'd0);
        head_valid = (count != '0);
        head_live  = head_valid && fifo_live[rd_ptr];
        a_win      = a_elig && (state == NORMAL);
        head_win   = head_live && !a_win;
        head_lose  = head_live && a_win && (head_addr != wb.a_addr);
        pop        = head_valid && (!fifo_live[rd_ptr] || head_win);
        push       = wb.b_valid && wb.b_ready;
        push_live  = (wb.b_addr != 5'd0) && !(a_win && (wb.b_addr == wb.a_addr));
    end

    always_comb begin
        next_state = state;
        wait_next  = '0;
        case (state)
            NORMAL: begin
                if (head_lose) begin
                    if (wait_cnt == WW'(STARVE_LIMIT - 1)) begin
                        next_state = STARVE;
                    end else begin
                        wait_next = wait_cnt + WW'(1);
                    end
                end
            end
            STARVE: begin
                if (head_win || !head_valid) begin
                    next_state = NORMAL;
                end
            end
            default: next_state = NORMAL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= NORMAL;
            wait_cnt <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= wait_next;
        end
    end

    // Liveness is cleared on pop too, so a set live bit always marks an occupied slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifo_live <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (a_win && (fifo_addr[i] == wb.a_addr)) begin
                    fifo_live[i] <= 1'b0;
                end
            end
            if (pop) begin
                fifo_live[rd_ptr] <= 1'b0;
                rd_ptr            <= rd_ptr + PW'(1);
            end
            if (push) begin
                fifo_live[wr_ptr] <= push_live;
                wr_ptr            <= wr_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= wb.b_addr;
            fifo_data[wr_ptr] <= wb.b_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RegWrite   <= 1'b0;
            w_reg_addr <= 5'd0;
            w_data     <= 32'd0;
            w_from_b   <= 1'b0;
        end else if (a_win) begin
            RegWrite   <= 1'b1;
            w_reg_addr <= wb.a_addr;
            w_data     <= wb.a_data;
            w_from_b   <= 1'b0;
        end else if (head_win) begin
            RegWrite   <= 1'b1;
            w_reg_addr <= head_addr;
            w_data     <= head_data;
            w_from_b   <= 1'b1;
        end else begin
            RegWrite   <= 1'b0;
            w_from_b   <= 1'b0;
        end
    end

    // A B result stays pending until it has left the write register.
    always_comb begin
        rs1_hit = RegWrite && w_from_b && (w_reg_addr == rs1_addr);
        rs2_hit = RegWrite && w_from_b && (w_reg_addr == rs2_addr);
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_live[i] && (fifo_addr[i] == rs1_addr)) rs1_hit = 1'b1;
            if (fifo_live[i] && (fifo_addr[i] == rs2_addr)) rs2_hit = 1'b1;
        end
        rs1_pending = rs1_hit && (rs1_addr != 5'd0);
        rs2_pending = rs2_hit && (rs2_addr != 5'd0);
    end

`ifdef RF_ARB_STATS_EN
    logic [CW-1:0] kills;
    logic [32:0]   kill_sum;

    always_comb begin
        kills = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (a_win && fifo_live[i] && (fifo_addr[i] == wb.a_addr)) kills = kills + CW'(1);
        end
        if (push && a_win && (wb.b_addr != 5'd0) && (wb.b_addr == wb.a_addr)) kills = kills + CW'(1);
        kill_sum = {1'b0, kill_cnt} + 33'(kills);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            conflict_cnt <= 32'd0;
            kill_cnt     <= 32'd0;
        end else begin
            if (a_win && head_live && (conflict_cnt != 32'hFFFF_FFFF)) begin
                conflict_cnt <= conflict_cnt + 32'd1;
            end
            kill_cnt <= kill_sum[32] ? 32'hFFFF_FFFF : kill_sum[31:0];
        end
    end
`endif

`ifndef SYNTHESIS
    a_during_stall: assert property (@(posedge clk) disable iff (!reset) wb.stall_a |-> !wb.a_valid)
        else $error("a_valid asserted while stall_a is high; A write dropped");
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus randomized traffic against a queue-based model.
`timescale 1ns/1ps
module tb_rf_wb_arbiter;
    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs1_addr, rs2_addr;
    logic        rs1_pending, rs2_pending;
    logic        RegWrite;
    logic [4:0]  w_reg_addr;
    logic [31:0] w_data;
`ifdef RF_ARB_STATS_EN
    logic [31:0] conflict_cnt, kill_cnt;
`endif

    rf_wb_arbiter_if wb ();

    rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk         (clk),
        .reset       (reset),
        .wb          (wb),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_pending (rs1_pending),
        .rs2_pending (rs2_pending),
        .RegWrite    (RegWrite),
        .w_reg_addr  (w_reg_addr),
        .w_data      (w_data)
`ifdef RF_ARB_STATS_EN
        ,
        .conflict_cnt(conflict_cnt),
        .kill_cnt    (kill_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        bit          live;
    } entry_t;

    // Reference model: B buffer as an ordered queue, plus the visible write register.
    entry_t      q[$];
    bit          m_starve;
    int          m_wait;
    bit          m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    bit          m_fromb;
    longint      m_conflicts, m_kills;

    int n_checks;
    int n_errors;
    bit cmp_en;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checkOutput(name, 32'(act), 32'(exp));
    endtask

    task automatic modelReset();
        q.delete();
        m_starve    = 1'b0;
        m_wait      = 0;
        m_we        = 1'b0;
        m_waddr     = 5'd0;
        m_wdata     = 32'd0;
        m_fromb     = 1'b0;
        m_conflicts = 0;
        m_kills     = 0;
    endtask

    function automatic bit modelPending(input logic [4:0] rs);
        bit hit;
        hit = m_we && m_fromb && (m_waddr == rs);
        foreach (q[i]) if (q[i].live && q[i].addr == rs) hit = 1'b1;
        return hit && (rs != 5'd0);
    endfunction

    // Advances the model by one clock edge using the inputs currently on the bus.
    task automatic modelStep();
        bit     a_el, a_won, has_head, head_live;
        int     size0;
        entry_t e;
        if (!reset) begin
            modelReset();
            return;
        end
        size0     = q.size();
        has_head  = size0 > 0;
        head_live = has_head && q[0].live;
        a_el      = wb.a_valid && (wb.a_addr != 5'd0);
        a_won     = a_el && !m_starve;
        if (a_won) begin
            if (head_live) m_conflicts++;
            if (head_live && q[0].addr != wb.a_addr) begin
                if (m_wait == STARVE_LIMIT - 1) begin
                    m_starve = 1'b1;
                    m_wait   = 0;
                end else begin
                    m_wait++;
                end
            end else begin
                m_wait = 0;
            end
            if (has_head && !head_live) void'(q.pop_front());
            foreach (q[i]) begin
                if (q[i].live && q[i].addr == wb.a_addr) begin
                    q[i].live = 1'b0;
                    m_kills++;
                end
            end
            m_we    = 1'b1;
            m_waddr = wb.a_addr;
            m_wdata = wb.a_data;
            m_fromb = 1'b0;
        end else begin
            m_wait  = 0;
            m_we    = 1'b0;
            m_fromb = 1'b0;
            if (head_live) begin
                m_we     = 1'b1;
                m_waddr  = q[0].addr;
                m_wdata  = q[0].data;
                m_fromb  = 1'b1;
                m_starve = 1'b0;
            end
            if (has_head) void'(q.pop_front());
            else m_starve = 1'b0;
        end
        if (wb.b_valid && size0 < DEPTH) begin
            e.addr = wb.b_addr;
            e.data = wb.b_data;
            e.live = (wb.b_addr != 5'd0) && !(a_won && wb.b_addr == wb.a_addr);
            if ((wb.b_addr != 5'd0) && a_won && wb.b_addr == wb.a_addr) m_kills++;
            q.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        modelStep();
    endtask

    // The pipeline honours stall_a, so A is withheld while the model is starving.
    task automatic applyStimulus(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                                 input logic bv, input logic [4:0] ba, input logic [31:0] bd);
        wb.a_valid = av && !m_starve;
        wb.a_addr  = aa;
        wb.a_data  = ad;
        wb.b_valid = bv;
        wb.b_addr  = ba;
        wb.b_data  = bd;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            checkBit("RegWrite", RegWrite, m_we);
            checkOutput("w_reg_addr", 32'(w_reg_addr), 32'(m_waddr));
            checkOutput("w_data", w_data, m_wdata);
            checkBit("stall_a", wb.stall_a, m_starve);
            checkBit("b_ready", wb.b_ready, q.size() < DEPTH);
            checkBit("rs1_pending", rs1_pending, modelPending(rs1_addr));
            checkBit("rs2_pending", rs2_pending, modelPending(rs2_addr));
`ifdef RF_ARB_STATS_EN
            checkOutput("conflict_cnt", conflict_cnt, m_conflicts[31:0]);
            checkOutput("kill_cnt", kill_cnt, m_kills[31:0]);
`endif
        end
    end

    initial begin
        int          writes9;
        logic [31:0] data9;
        longint      kills0;

        n_checks = 0;
        n_errors = 0;
        reset    = 1'b0;
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;
        modelReset();
        idle();
        cmp_en = 1'b1;

        repeat (2) tick();
        checkBit("reset_RegWrite", RegWrite, 1'b0);
        checkOutput("reset_w_reg_addr", 32'(w_reg_addr), 32'd0);
        checkOutput("reset_w_data", w_data, 32'd0);
        checkBit("reset_stall_a", wb.stall_a, 1'b0);
        checkBit("reset_b_ready", wb.b_ready, 1'b1);
        reset = 1'b1;
        tick();

        // A only: one-cycle latency.
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        tick();
        idle();
        checkBit("a_only_we", RegWrite, 1'b1);
        checkOutput("a_only_addr", 32'(w_reg_addr), 32'd5);
        checkOutput("a_only_data", w_data, 32'hDEADBEEF);
        checkBit("a_only_model_we", m_we, 1'b1);
        tick();
        checkBit("a_only_done", RegWrite, 1'b0);

        // B only: pending at N+1, write at N+2, clear at N+3.
        rs1_addr = 5'd7;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h12);
        tick();
        idle();
        checkBit("b_only_pend_n1", rs1_pending, 1'b1);
        checkBit("b_only_model_pend_n1", modelPending(5'd7), 1'b1);
        checkBit("b_only_no_write_n1", RegWrite, 1'b0);
        tick();
        checkBit("b_only_we_n2", RegWrite, 1'b1);
        checkOutput("b_only_addr_n2", 32'(w_reg_addr), 32'd7);
        checkOutput("b_only_data_n2", w_data, 32'h12);
        checkBit("b_only_pend_n2", rs1_pending, 1'b1);
        tick();
        checkBit("b_only_pend_n3", rs1_pending, 1'b0);
        checkBit("b_only_model_pend_n3", modelPending(5'd7), 1'b0);

        // WAW: a younger A write to reg 9 kills the buffered B value.
        kills0 = m_kills;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h1);
        tick();
        applyStimulus(1'b1, 5'd9, 32'h2, 1'b0, 5'd0, 32'd0);
        writes9 = 0;
        data9   = 32'd0;
        for (int k = 0; k < 5; k++) begin
            tick();
            idle();
            if (RegWrite && w_reg_addr == 5'd9) begin
                writes9++;
                data9 = w_data;
            end
        end
        checkOutput("waw_write_count", 32'(writes9), 32'd1);
        checkOutput("waw_data", data9, 32'h2);
        checkOutput("waw_model_kills", 32'(m_kills - kills0), 32'd1);
`ifdef RF_ARB_STATS_EN
        checkOutput("waw_kill_cnt", kill_cnt, 32'd1);
`endif

        // Starvation: head at reg 12 loses to A eight times, then forces its write.
        applyStimulus(1'b1, 5'd3, 32'hA0, 1'b1, 5'd12, 32'hBB);
        tick();
        for (int k = 1; k <= STARVE_LIMIT; k++) begin
            applyStimulus(1'b1, 5'd3, 32'(k), 1'b0, 5'd0, 32'd0);
            tick();
            if (k >= STARVE_LIMIT - 1) begin
                checkBit($sformatf("starve_stall_after_%0d", k), wb.stall_a, k == STARVE_LIMIT);
            end
        end
        checkBit("starve_model_stall", m_starve, 1'b1);
        applyStimulus(1'b1, 5'd3, 32'hCC, 1'b0, 5'd0, 32'd0);
        tick();
        idle();
        checkBit("starve_head_we", RegWrite, 1'b1);
        checkOutput("starve_head_addr", 32'(w_reg_addr), 32'd12);
        checkOutput("starve_head_data", w_data, 32'hBB);
        checkBit("starve_stall_drop", wb.stall_a, 1'b0);
        repeat (2) tick();

        // Fill: four accepts while A is busy, then full until the head drains.
        for (int k = 0; k < DEPTH; k++) begin
            applyStimulus(1'b1, 5'd4, 32'(k), 1'b1, 5'(16 + k), 32'(100 + k));
            tick();
        end
        idle();
        checkBit("fill_b_ready_full", wb.b_ready, 1'b0);
        tick();
        checkBit("fill_b_ready_after_deq", wb.b_ready, 1'b1);
        repeat (DEPTH + 2) tick();

        // Reset in the middle of traffic with three entries buffered.
        rs1_addr = 5'd21;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 5'd4, 32'(k), 1'b1, 5'(21 + k), 32'(200 + k));
            tick();
        end
        checkBit("mid_reset_pend_before", rs1_pending, 1'b1);
        reset = 1'b0;
        idle();
        modelReset();
        tick();
        checkBit("mid_reset_we", RegWrite, 1'b0);
        checkBit("mid_reset_b_ready", wb.b_ready, 1'b1);
        checkBit("mid_reset_pend", rs1_pending, 1'b0);
        reset = 1'b1;
        writes9 = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (RegWrite) writes9++;
        end
        checkOutput("mid_reset_no_stale_writes", 32'(writes9), 32'd0);

        // Randomized traffic with varying A pressure and a small address range for collisions.
        for (int seg = 0; seg < 8; seg++) begin
            int pa;
            pa = (seg % 3 == 0) ? 95 : ((seg % 3 == 1) ? 60 : 25);
            for (int c = 0; c < 100; c++) begin
                applyStimulus($urandom_range(0, 99) < pa, 5'($urandom_range(0, 7)), $urandom(),
                              $urandom_range(0, 99) < 50, 5'($urandom_range(0, 7)), $urandom());
                rs1_addr = 5'($urandom_range(0, 7));
                rs2_addr = 5'($urandom_range(0, 7));
                tick();
            end
            if (seg == 4) begin
                reset = 1'b0;
                modelReset();
                tick();
                reset = 1'b1;
            end
        end

        idle();
        tick();
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
